// File: rtl/t07_spi_tft_tx.sv
// t07_spi_tft_tx -- FIFO-buffered, mode-0 SPI transmitter for a TFT panel.
// Each FIFO entry carries a word and its data/command flag. A word is sent MSB
// first inside one cs_n-low window, and cs_n is then held high for CS_GAP ticks.
// Build option: define T07_SPI_DELAY_EN to add delay entries (wr_delay port,
// WAIT state). A delay entry stalls the stream for wr_data ticks with cs_n high.
module t07_spi_tft_tx #(
  parameter int DATA_W = 16,
  parameter int DIV    = 19,
  parameter int DEPTH  = 4,
  parameter int CS_GAP = 2
) (
  input  logic              hwclk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_dc,
`ifdef T07_SPI_DELAY_EN
  input  logic              wr_delay,
`endif
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              dc
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DVW = $clog2(DIV);
  localparam int BCW = $clog2(DATA_W);
  localparam int GCW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
`ifdef T07_SPI_DELAY_EN
  localparam int EW = DATA_W + 2;
  localparam logic [DATA_W-1:0] SH_ONE = DATA_W'(1);
`else
  localparam int EW = DATA_W + 1;
`endif

  localparam logic [DVW-1:0] DIV_LAST = DVW'(DIV - 1);
  localparam logic [DVW-1:0] DIV_ONE  = DVW'(1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(CS_GAP - 1);
  localparam logic [GCW-1:0] GAP_ONE  = GCW'(1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

`ifdef T07_SPI_DELAY_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    WAIT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;
`endif

  // FSM and serializer state
  state_t            r_state, w_state_nxt;
  logic [DVW-1:0]    r_div, w_div_nxt;
  logic [BCW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [GCW-1:0]    r_gap_cnt, w_gap_cnt_nxt;
  logic [DATA_W-1:0] r_sh, w_sh_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_cs_n, w_cs_n_nxt;
  logic              r_dc, w_dc_nxt;
  logic              r_done, w_done_nxt;
  logic              r_busy;
  logic              r_ovf;

  // FIFO state
  logic [EW-1:0]     r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              r_full, r_empty;

  logic              w_push, w_pop, w_tick;
  logic [EW-1:0]     w_wr_entry, w_head;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_dc;
`ifdef T07_SPI_DELAY_EN
  logic              w_head_delay;
`endif

  // Full is the registered flag, so a pop in the same cycle cannot rescue a push.
  assign w_push = wr_en & ~r_full;
  assign w_pop  = (r_state == IDLE) & ~r_empty;
  assign w_tick = (r_div == DIV_LAST);
  assign w_head = r_mem[r_rd_ptr];
  assign w_head_data = w_head[DATA_W-1:0];
  assign w_head_dc   = w_head[DATA_W];
`ifdef T07_SPI_DELAY_EN
  assign w_wr_entry   = {wr_delay, wr_dc, wr_data};
  assign w_head_delay = w_head[DATA_W+1];
`else
  assign w_wr_entry   = {wr_dc, wr_data};
`endif

  // Occupancy for the next cycle from this cycle's push/pop pair
  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
      2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // FIFO pointers, occupancy, flags and the sticky overflow bit
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_FULL);
      r_empty <= (w_cnt_nxt == '0);
      if (wr_en && r_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Entry storage; contents are only meaningful between push and pop
  always_ff @(posedge hwclk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Next-state and serializer logic; every register holds unless a rule fires
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_sh_nxt      = r_sh;
    w_sclk_nxt    = r_sclk;
    w_cs_n_nxt    = r_cs_n;
    w_dc_nxt      = r_dc;
    w_done_nxt    = 1'b0;
    w_div_nxt     = '0;

    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_sh_nxt      = w_head_data;
          w_state_nxt   = SHIFT;
          w_cs_n_nxt    = 1'b0;
          w_dc_nxt      = w_head_dc;
          w_bit_cnt_nxt = BIT_LAST;
`ifdef T07_SPI_DELAY_EN
          // A delay entry reuses the shift register as its tick countdown.
          if (w_head_delay) begin
            w_state_nxt   = WAIT;
            w_cs_n_nxt    = r_cs_n;
            w_dc_nxt      = r_dc;
            w_bit_cnt_nxt = r_bit_cnt;
          end else begin
            w_state_nxt   = SHIFT;
          end
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end

      SHIFT: begin
        if (w_tick) begin
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else begin
            w_sclk_nxt = 1'b0;
            if (r_bit_cnt == '0) begin
              w_state_nxt   = GAP;
              w_cs_n_nxt    = 1'b1;
              w_done_nxt    = 1'b1;
              w_gap_cnt_nxt = '0;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt - BIT_ONE;
              w_sh_nxt      = {r_sh[DATA_W-2:0], 1'b0};
            end
          end
        end else begin
          w_sclk_nxt = r_sclk;
        end
      end

      GAP: begin
        if (w_tick) begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_nxt = IDLE;
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + GAP_ONE;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt;
        end
      end

`ifdef T07_SPI_DELAY_EN
      WAIT: begin
        if (r_sh == '0) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          if (r_sh == SH_ONE) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_sh_nxt = r_sh - SH_ONE;
          end
        end else begin
          w_sh_nxt = r_sh;
        end
      end
`endif

      default: begin
        w_state_nxt = IDLE;
        w_cs_n_nxt  = 1'b1;
        w_sclk_nxt  = 1'b0;
      end
    endcase

    // The tick divider only runs while a word, gap or delay is in progress.
    if ((r_state == IDLE) || (w_state_nxt == IDLE) || w_tick) begin
      w_div_nxt = '0;
    end else begin
      w_div_nxt = r_div + DIV_ONE;
    end
  end

  // FSM state and serializer registers; reset abandons any word in flight
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_sh      <= '0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_dc      <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= w_div_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_sh      <= w_sh_nxt;
      r_sclk    <= w_sclk_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_dc      <= w_dc_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  assign full  = r_full;
  assign empty = r_empty;
  assign busy  = r_busy;
  assign done  = r_done;
  assign ovf   = r_ovf;
  assign sclk  = r_sclk;
  assign mosi  = r_sh[DATA_W-1];
  assign cs_n  = r_cs_n;
  assign dc    = r_dc;

endmodule

// File: tb/tb_t07_spi_tft_tx.sv
// Self-checking bench for t07_spi_tft_tx (DATA_W=16, DIV=4, DEPTH=4, CS_GAP=2).
// A negedge monitor turns the SPI pins into per-window records (bits seen at
// sclk rises, window length, dc, preceding cs_n-high run). These records are
// compared with a queue of words the bench expects to see on the wire.
module tb_t07_spi_tft_tx;
  localparam int DATA_W   = 16;
  localparam int DIV      = 4;
  localparam int DEPTH    = 4;
  localparam int CS_GAP   = 2;
  localparam int WORD_CYC = 2 * DATA_W * DIV;
  localparam int GAP_CYC  = CS_GAP * DIV + 1;

  logic              hwclk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_dc;
`ifdef T07_SPI_DELAY_EN
  logic              wr_delay;
`endif
  logic full, empty, busy, done, ovf, sclk, mosi, cs_n, dc;

  t07_spi_tft_tx #(.DATA_W(DATA_W), .DIV(DIV), .DEPTH(DEPTH), .CS_GAP(CS_GAP)) dut (
    .hwclk(hwclk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_dc(wr_dc),
`ifdef T07_SPI_DELAY_EN
    .wr_delay(wr_delay),
`endif
    .full(full), .empty(empty), .busy(busy), .done(done), .ovf(ovf),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .dc(dc)
  );

  always #5 hwclk = ~hwclk;

  int checks = 0;
  int failures = 0;

  // Monitor state and per-window records
  int          mon_rises = 0, mon_unstable = 0, mon_done = 0;
  int          mon_low = 0, mon_high = 0, mon_cur_n = 0;
  logic [31:0] mon_bits = '0;
  bit          mon_in_win = 1'b0, mon_dc_ok = 1'b1;
  logic        mon_win_dc = 1'b0, mon_prev_sclk = 1'b0, mon_prev_mosi = 1'b0;
  logic [31:0] q_word[$];
  int          q_nbits[$];
  int          q_low[$];
  logic        q_dc[$];
  bit          q_dcok[$];
  int          q_gap[$];

  // Expected wire traffic: {dc, word} and required preceding gap (-1 = any)
  logic [16:0] exp_q[$];
  int          exp_gap[$];
  int          exp_done = 0;
  int          rd = 0;

  // Pin monitor sampled mid-cycle
  always @(negedge hwclk) begin
    if (cs_n === 1'b0) begin
      if (!mon_in_win) begin
        mon_in_win = 1'b1;
        q_gap.push_back(mon_high);
        mon_bits = '0; mon_cur_n = 0; mon_low = 0;
        mon_win_dc = dc; mon_dc_ok = 1'b1;
      end
      mon_low++;
      if (dc !== mon_win_dc) mon_dc_ok = 1'b0;
      if (sclk === 1'b1 && mon_prev_sclk === 1'b0) begin
        mon_bits = {mon_bits[30:0], mosi};
        mon_cur_n++;
        mon_rises++;
        if (mosi !== mon_prev_mosi) mon_unstable++;
      end
    end else begin
      if (mon_in_win) begin
        mon_in_win = 1'b0;
        q_word.push_back(mon_bits); q_nbits.push_back(mon_cur_n);
        q_low.push_back(mon_low); q_dc.push_back(mon_win_dc); q_dcok.push_back(mon_dc_ok);
        mon_high = 0;
      end
      mon_high++;
      if (sclk === 1'b1 && mon_prev_sclk === 1'b0) mon_rises++;
    end
    mon_prev_sclk = sclk;
    mon_prev_mosi = mosi;
    if (done === 1'b1) mon_done++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_word(input logic [15:0] w, input logic d);
    wr_en = 1'b1; wr_data = w; wr_dc = d;
    @(posedge hwclk); #1;
    wr_en = 1'b0;
  endtask

  task automatic expect_word(input logic [15:0] w, input logic d, input int g);
    exp_q.push_back({d, w});
    exp_gap.push_back(g);
    exp_done++;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge hwclk);
    while (!(busy === 1'b0 && empty === 1'b1) && n < budget) begin
      @(negedge hwclk);
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  // Compare every expected word against the next monitor record
  task automatic check_words();
    logic [16:0] e;
    int g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = exp_gap.pop_front();
      check("word_present", 32'(rd < q_word.size()), 32'd1);
      if (rd < q_word.size()) begin
        check("word_bits", q_word[rd], {16'h0000, e[15:0]});
        check("word_nbits", q_nbits[rd], DATA_W);
        check("cs_low_cycles", q_low[rd], WORD_CYC);
        check("word_dc", 32'(q_dc[rd]), 32'(e[16]));
        check("dc_stable", 32'(q_dcok[rd]), 32'd1);
        if (g >= 0) check("cs_gap", q_gap[rd], g);
        rd++;
      end
    end
  endtask

  // Hard stop if the bench itself stalls
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w, w2;
    logic        d;
    int          n, base;
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; wr_dc = 1'b0;
`ifdef T07_SPI_DELAY_EN
    wr_delay = 1'b0;
`endif
    repeat (3) @(negedge hwclk);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_dc", 32'(dc), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge hwclk);
    #1; rd = q_word.size();

    // Single known word: latency from write to cs_n fall, then the full frame
    @(negedge hwclk);
    push_word(16'hA5F0, 1'b1);
    check("write_edge_cs_n", 32'(cs_n), 32'd1);
    check("write_edge_empty", 32'(empty), 32'd0);
    @(posedge hwclk); #1;
    check("pop_cs_n", 32'(cs_n), 32'd0);
    check("pop_busy", 32'(busy), 32'd1);
    check("pop_dc", 32'(dc), 32'd1);
    check("pop_mosi_msb", 32'(mosi), 32'd1);
    expect_word(16'hA5F0, 1'b1, -1);
    wait_idle(600);
    check_words();
    check("ovf_clear", 32'(ovf), 32'd0);

    // Random isolated words
    for (int k = 0; k < 3; k++) begin
      @(negedge hwclk);
      w = 16'($urandom); d = 1'($urandom);
      push_word(w, d);
      expect_word(w, d, -1);
      wait_idle(600);
      check_words();
    end

    // Six consecutive pushes: the first goes straight into service, DEPTH more
    // are queued, the sixth finds the FIFO full and is dropped.
    @(negedge hwclk);
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 16'($urandom); wr_dc = 1'($urandom);
      if (i <= DEPTH) expect_word(wr_data, wr_dc, (i == 0) ? -1 : GAP_CYC);
      @(posedge hwclk); #1;
    end
    wr_en = 1'b0;
    check("burst_full", 32'(full), 32'd1);
    check("burst_ovf", 32'(ovf), 32'd1);
    wait_idle(2000);
    check_words();
    check("ovf_sticky", 32'(ovf), 32'd1);
    check("drained_full", 32'(full), 32'd0);

    // Command then data word, back to back
    @(negedge hwclk);
    wr_en = 1'b1; wr_data = 16'h002A; wr_dc = 1'b0;
    @(posedge hwclk); #1;
    wr_data = 16'h0000; wr_dc = 1'b1;
    @(posedge hwclk); #1;
    wr_en = 1'b0;
    expect_word(16'h002A, 1'b0, -1);
    expect_word(16'h0000, 1'b1, GAP_CYC);
    wait_idle(1000);
    check_words();

    // Reset in the middle of the 8th bit with a second word still queued
    @(negedge hwclk);
    w = 16'($urandom); w2 = 16'($urandom);
    wr_en = 1'b1; wr_data = w; wr_dc = 1'b1;
    @(posedge hwclk); #1;
    wr_data = w2;
    @(posedge hwclk); #1;
    wr_en = 1'b0;
    n = 0;
    while (mon_cur_n != 8 && n < 400) begin
      @(negedge hwclk); #1;
      n++;
    end
    check("bit8_reached", 32'(n < 400), 32'd1);
    check("pre_rst_cs_n", 32'(cs_n), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("arst_cs_n", 32'(cs_n), 32'd1);
    check("arst_sclk", 32'(sclk), 32'd0);
    check("arst_mosi", 32'(mosi), 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_dc", 32'(dc), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge hwclk);
    reset = 1'b0;
    @(negedge hwclk); #1;
    rd = q_word.size();
    base = mon_rises;
    repeat (200) @(negedge hwclk);
    #1;
    check("no_resume_sclk", mon_rises, base);
    check("no_resume_cs_n", 32'(cs_n), 32'd1);
    check("no_resume_busy", 32'(busy), 32'd0);
    check("no_resume_empty", 32'(empty), 32'd1);

    // Normal traffic after reset
    @(negedge hwclk);
    w = 16'($urandom); d = 1'($urandom);
    push_word(w, d);
    expect_word(w, d, -1);
    wait_idle(600);
    check_words();

`ifdef T07_SPI_DELAY_EN
    // Delay entry of 3 ticks followed by a normal word
    @(negedge hwclk);
    wr_en = 1'b1; wr_delay = 1'b1; wr_data = 16'd3; wr_dc = 1'b0;
    @(posedge hwclk); #1;
    wr_delay = 1'b0; wr_data = 16'h1234; wr_dc = 1'b1;
    @(posedge hwclk); #1;
    wr_en = 1'b0;
    n = 0; base = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge hwclk); #1;
      if (done !== 1'b1) begin
        n++;
        if (cs_n !== 1'b1 || sclk !== 1'b0) base++;
      end
    end
    check("delay_cycles", n, 12);
    check("delay_quiet", base, 0);
    exp_done++;
    expect_word(16'h1234, 1'b1, -1);
    wait_idle(600);
    check_words();
`endif

    check("mosi_stable_at_rise", mon_unstable, 0);
    check("done_pulses", mon_done, exp_done);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
